pwm_ramp_controller: RTL and testbench

Sequencer that drives the duty-cycle input of the PWM datapath (clock divider, resolution counter, comparator). It soft-starts the output by ramping the duty from 0 toward a requested target. It stepwise re-targets on the fly and soft-stops back to 0 when disabled. A fault input forces an immediate hard shutdown. It steps only on PWM period boundaries, signalled by the resolution counter's wrap pulse.

---
 rtl/pwm_ramp_controller.sv | 156 +++++++++++++++
 tb/tb_pwm_ramp_controller.sv | 274 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/pwm_ramp_controller.sv
// Duty-cycle sequencer for the PWM datapath: soft start, live retarget,
// soft stop and fault shutdown, stepping only on PWM period wraps.
module pwm_ramp_controller #(
  parameter int DUTY_W         = 8,
  parameter int STEP           = 1,
  parameter int TICKS_PER_STEP = 4
) (
  input  logic              clk,
  input  logic              rst_a,
  input  logic              enable,
  input  logic [DUTY_W-1:0] target_duty,
  input  logic              period_tick,
  input  logic              fault,
  output logic [DUTY_W-1:0] duty_out,
  output logic              pwm_en,
  output logic              at_target,
  output logic              busy,
  output logic              stopped,
  output logic              fault_flag
);

  typedef enum logic [2:0] {
    IDLE,
    RAMP,
    HOLD,
    STOP,
    FAULT
  } state_t;

  localparam int TW =
    (TICKS_PER_STEP > 1) ? $clog2(TICKS_PER_STEP) : 1;
  localparam logic [TW-1:0] T_LAST = TW'(TICKS_PER_STEP - 1);
  localparam logic [DUTY_W:0] STEP_V = (DUTY_W + 1)'(STEP);

  state_t            state;
  logic [DUTY_W-1:0] tgt_q;
  logic [TW-1:0]     tick_cnt;
  logic [DUTY_W-1:0] ramp_next;
  logic [DUTY_W-1:0] stop_next;
  logic              term;

  // Signed distance at DUTY_W+1 bits; step clipped so it never overshoots.
  function automatic logic [DUTY_W-1:0] toward(
    input logic [DUTY_W-1:0] cur,
    input logic [DUTY_W-1:0] dst
  );
    logic [DUTY_W:0] diff;
    logic [DUTY_W:0] mag;
    logic [DUTY_W:0] amt;
    diff = {1'b0, dst} - {1'b0, cur};
    mag  = diff[DUTY_W] ? -diff : diff;
    amt  = (mag < STEP_V) ? mag : STEP_V;
    return diff[DUTY_W] ? cur - amt[DUTY_W-1:0]
                        : cur + amt[DUTY_W-1:0];
  endfunction

  assign ramp_next = toward(duty_out, tgt_q);
  assign stop_next = toward(duty_out, {DUTY_W{1'b0}});
  assign term      = period_tick && (tick_cnt == T_LAST);

  always_ff @(posedge clk) begin
    if (!rst_a) begin
      state      <= IDLE;
      duty_out   <= '0;
      pwm_en     <= 1'b0;
      at_target  <= 1'b0;
      busy       <= 1'b0;
      stopped    <= 1'b0;
      fault_flag <= 1'b0;
      tgt_q      <= '0;
      tick_cnt   <= '0;
    end else begin
      stopped <= 1'b0;
      if (fault && state != FAULT) begin
        state      <= FAULT;
        duty_out   <= '0;
        pwm_en     <= 1'b0;
        at_target  <= 1'b0;
        busy       <= 1'b0;
        fault_flag <= 1'b1;
        tick_cnt   <= '0;
      end else begin
        unique case (state)
          IDLE: begin
            duty_out <= '0;
            if (enable) begin
              tgt_q    <= target_duty;
              tick_cnt <= '0;
              state    <= RAMP;
              pwm_en   <= 1'b1;
              busy     <= 1'b1;
            end
          end
          RAMP: begin
            if (!enable) begin
              state    <= STOP;
              tick_cnt <= '0;
            end else if (duty_out == tgt_q) begin
              // tgt_q frozen here so HOLD always starts with duty == tgt_q
              state     <= HOLD;
              at_target <= 1'b1;
              busy      <= 1'b0;
              tick_cnt  <= '0;
            end else begin
              tgt_q <= target_duty;
              if (term) begin
                duty_out <= ramp_next;
                tick_cnt <= '0;
              end else if (period_tick) begin
                tick_cnt <= tick_cnt + 1'b1;
              end
            end
          end
          HOLD: begin
            if (!enable) begin
              state     <= STOP;
              at_target <= 1'b0;
              busy      <= 1'b1;
              tick_cnt  <= '0;
            end else if (target_duty != tgt_q) begin
              tgt_q     <= target_duty;
              state     <= RAMP;
              at_target <= 1'b0;
              busy      <= 1'b1;
            end
          end
          STOP: begin
            if (enable) begin
              tgt_q    <= target_duty;
              state    <= RAMP;
              tick_cnt <= '0;
            end else if (duty_out == '0) begin
              state   <= IDLE;
              pwm_en  <= 1'b0;
              busy    <= 1'b0;
              stopped <= 1'b1;
            end else if (term) begin
              duty_out <= stop_next;
              tick_cnt <= '0;
            end else if (period_tick) begin
              tick_cnt <= tick_cnt + 1'b1;
            end
          end
          FAULT: begin
            if (!fault && !enable) begin
              state      <= IDLE;
              fault_flag <= 1'b0;
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_pwm_ramp_controller.sv
// Scoreboard bench: two configurations share stimulus, each checked
// every cycle against an arithmetic reference model.
module tb_pwm_ramp_controller;

  localparam int M_IDLE  = 0;
  localparam int M_RAMP  = 1;
  localparam int M_HOLD  = 2;
  localparam int M_STOP  = 3;
  localparam int M_FAULT = 4;

  typedef struct {
    int mode;
    int duty;
    int tgt;
    int ticks;
    bit stp;
  } mdl_t;

  logic       clk;
  logic       rst_a;
  logic       enable;
  logic [7:0] target_duty;
  logic       period_tick;
  logic       fault;

  logic [7:0] duty_a, duty_b;
  logic pwm_a, at_a, busy_a, stp_a, ff_a;
  logic pwm_b, at_b, busy_b, stp_b, ff_b;

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  mdl_t ma, mb;
  logic [12:0] qa[$];
  logic [12:0] qb[$];

  pwm_ramp_controller #(
    .DUTY_W(8), .STEP(4), .TICKS_PER_STEP(2)
  ) dut_a (
    .clk(clk), .rst_a(rst_a), .enable(enable),
    .target_duty(target_duty), .period_tick(period_tick),
    .fault(fault), .duty_out(duty_a), .pwm_en(pwm_a),
    .at_target(at_a), .busy(busy_a), .stopped(stp_a),
    .fault_flag(ff_a)
  );

  pwm_ramp_controller #(
    .DUTY_W(8), .STEP(255), .TICKS_PER_STEP(1)
  ) dut_b (
    .clk(clk), .rst_a(rst_a), .enable(enable),
    .target_duty(target_duty), .period_tick(period_tick),
    .fault(fault), .duty_out(duty_b), .pwm_en(pwm_b),
    .at_target(at_b), .busy(busy_b), .stopped(stp_b),
    .fault_flag(ff_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic int approach(int c, int d, int s);
    if (d > c) return c + ((d - c < s) ? d - c : s);
    return c - ((c - d < s) ? c - d : s);
  endfunction

  function automatic mdl_t mnext(mdl_t m, bit en, int tin,
                                 bit tk, bit flt, bit rst,
                                 int step, int tps);
    mdl_t n;
    n = m;
    n.stp = 0;
    if (!rst) begin
      n = '{M_IDLE, 0, 0, 0, 0};
      return n;
    end
    if (flt && m.mode != M_FAULT) begin
      n.mode = M_FAULT;
      n.duty = 0;
      n.ticks = 0;
      return n;
    end
    case (m.mode)
      M_IDLE: if (en) begin
        n.mode = M_RAMP;
        n.tgt = tin;
        n.ticks = 0;
      end
      M_RAMP: begin
        if (!en) begin
          n.mode = M_STOP;
          n.ticks = 0;
        end else if (m.duty == m.tgt) begin
          n.mode = M_HOLD;
          n.ticks = 0;
        end else begin
          n.tgt = tin;
          if (tk && m.ticks == tps - 1) begin
            n.ticks = 0;
            n.duty = approach(m.duty, m.tgt, step);
          end else if (tk) begin
            n.ticks = m.ticks + 1;
          end
        end
      end
      M_HOLD: begin
        if (!en) begin
          n.mode = M_STOP;
          n.ticks = 0;
        end else if (tin != m.tgt) begin
          n.mode = M_RAMP;
          n.tgt = tin;
        end
      end
      M_STOP: begin
        if (en) begin
          n.mode = M_RAMP;
          n.tgt = tin;
          n.ticks = 0;
        end else if (m.duty == 0) begin
          n.mode = M_IDLE;
          n.stp = 1;
        end else if (tk && m.ticks == tps - 1) begin
          n.ticks = 0;
          n.duty = approach(m.duty, 0, step);
        end else if (tk) begin
          n.ticks = m.ticks + 1;
        end
      end
      default: if (!en) n.mode = M_IDLE;
    endcase
    return n;
  endfunction

  function automatic logic [12:0] pk(mdl_t m);
    logic pwm, at, bsy, ff;
    pwm = m.mode inside {M_RAMP, M_HOLD, M_STOP};
    at  = m.mode == M_HOLD;
    bsy = m.mode inside {M_RAMP, M_STOP};
    ff  = m.mode == M_FAULT;
    return {8'(m.duty), pwm, at, bsy, m.stp, ff};
  endfunction

  task automatic cmp(string nm, logic [12:0] act,
                     logic [12:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s t=%0t got duty=%0d flags=%b want duty=%0d flags=%b",
               nm, $time, act[12:5], act[4:0],
               exp[12:5], exp[4:0]);
    end
  endtask

  always @(negedge clk) begin
    if (qa.size() > 0)
      cmp("scb_a", {duty_a, pwm_a, at_a, busy_a, stp_a, ff_a},
          qa.pop_front());
    if (qb.size() > 0)
      cmp("scb_b", {duty_b, pwm_b, at_b, busy_b, stp_b, ff_b},
          qb.pop_front());
  end

  task automatic check(string nm, int act, int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s got=%0d want=%0d", nm, act, exp);
    end
  endtask

  task automatic cyc1(bit en, int tgt, bit tk, bit flt, bit rst);
    rst_a = rst;
    enable = en;
    target_duty = 8'(tgt);
    period_tick = tk;
    fault = flt;
    ma = mnext(ma, en, tgt, tk, flt, rst, 4, 2);
    mb = mnext(mb, en, tgt, tk, flt, rst, 255, 1);
    qa.push_back(pk(ma));
    qb.push_back(pk(mb));
    cyc++;
    @(posedge clk);
    #1;
  endtask

  task automatic run(int n, bit en, int tgt);
    for (int i = 0; i < n; i++)
      cyc1(en, tgt, (cyc % 5) == 0, 1'b0, 1'b1);
  endtask

  task automatic wait_a(int v, bit en, int tgt, int lim);
    int k;
    k = 0;
    while (duty_a != 8'(v) && k < lim) begin
      run(1, en, tgt);
      k++;
    end
    check("wait_duty_a", duty_a, v);
  endtask

  initial begin
    ma = '{M_IDLE, 0, 0, 0, 0};
    mb = '{M_IDLE, 0, 0, 0, 0};
    cyc1(1, 10, 0, 1, 0);
    check("rst_duty", duty_a, 0);
    check("rst_flags", {pwm_a, busy_a, ff_a, at_a}, 0);
    cyc1(1, 10, 0, 1, 0);
    run(50, 1, 10);
    check("ramp_duty_a", duty_a, 10);
    check("ramp_at_a", at_a, 1);
    check("ramp_duty_b", duty_b, 10);
    // reset pulse entirely between edges must be ignored
    rst_a = 1'b1;
    ma = mnext(ma, 1, 10, 0, 0, 1, 4, 2);
    mb = mnext(mb, 1, 10, 0, 0, 1, 255, 1);
    qa.push_back(pk(ma));
    qb.push_back(pk(mb));
    #2 rst_a = 1'b0;
    #1 rst_a = 1'b1;
    @(posedge clk);
    #1;
    check("glitch_duty", duty_a, 10);
    run(40, 1, 2);
    check("down_duty", duty_a, 2);
    run(700, 1, 250);
    run(40, 1, 255);
    check("top_duty", duty_a, 255);
    run(700, 1, 10);
    check("back_duty", duty_a, 10);
    run(40, 0, 10);
    check("stop_duty", duty_a, 0);
    check("stop_pwm", pwm_a, 0);
    run(60, 1, 10);
    wait_a(6, 0, 10, 40);
    run(60, 1, 20);
    check("reen_duty", duty_a, 20);
    run(80, 0, 20);
    wait_a(8, 1, 40, 60);
    cyc1(1, 40, 0, 1, 1);
    check("flt_duty", duty_a, 0);
    check("flt_flag", ff_a, 1);
    run(5, 1, 40);
    check("flt_hold", ff_a, 1);
    run(1, 0, 40);
    check("flt_exit", ff_a, 0);
    cyc1(1, 200, 0, 0, 1);
    cyc1(1, 200, 0, 0, 1);
    cyc1(1, 200, 1, 0, 1);
    check("b_one_step", duty_b, 200);
    cyc1(1, 100, 0, 0, 1);
    cyc1(1, 100, 0, 0, 1);
    cyc1(0, 100, 1, 0, 1);
    check("b_fall_nostep", duty_b, 200);
    check("b_fall_busy", busy_b, 1);
    begin
      bit en;
      int tg;
      en = 1;
      tg = 30;
      for (int i = 0; i < 3000; i++) begin
        if ($urandom_range(0, 39) == 0) en = !en;
        if ($urandom_range(0, 29) == 0) tg = $urandom_range(0, 255);
        cyc1(en, tg, $urandom_range(0, 2) == 0,
             $urandom_range(0, 149) == 0,
             $urandom_range(0, 499) != 0);
      end
    end
    @(negedge clk);
    #1;
    check("queue_drain", qa.size() + qb.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
